// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// One result bit per cycle: shift-add multiply, restoring divide, then a
// single sign-fix cycle. Direct HI/LO writes are honoured only while idle.
module muldiv_seq #(
    parameter int unsigned WIDE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [WIDE-1:0] i_a,
    input  logic [WIDE-1:0] i_b,
    input  logic            i_we_hi,
    input  logic            i_we_lo,
    input  logic [WIDE-1:0] i_wd,
    output logic [WIDE-1:0] o_hi,
    output logic [WIDE-1:0] o_lo,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_div_zero
);

    localparam int unsigned CW = $clog2(WIDE) + 1;
    localparam int unsigned W2 = 2 * WIDE;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [W2-1:0]   r_acc, w_acc_nxt;
    logic [WIDE-1:0] r_m, w_m_nxt;
    logic [WIDE-1:0] r_b, w_b_nxt;
    logic [WIDE-1:0] r_a, w_a_nxt;
    logic            r_div, w_div_nxt;
    logic            r_sign_q, w_sign_q_nxt;
    logic            r_sign_r, w_sign_r_nxt;
    logic            r_dz, w_dz_nxt;
    logic [WIDE-1:0] r_hi, w_hi_nxt;
    logic [WIDE-1:0] r_lo, w_lo_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_div_zero, w_div_zero_nxt;

    // Operand magnitudes (signed modes take absolute values)
    logic            w_sgn;
    logic [WIDE-1:0] w_a_abs, w_b_abs;
    assign w_sgn   = i_op[0];
    assign w_a_abs = (w_sgn && i_a[WIDE-1]) ? ((~i_a) + WIDE'(1)) : i_a;
    assign w_b_abs = (w_sgn && i_b[WIDE-1]) ? ((~i_b) + WIDE'(1)) : i_b;

    // One iteration of each algorithm
    logic [W2-1:0]   w_mul_acc, w_div_acc;
    logic [WIDE:0]   w_rem_sh;
    logic            w_ge;
    logic [WIDE-1:0] w_rem_new;
    assign w_mul_acc = {r_acc[W2-2:0], 1'b0} + (r_m[WIDE-1] ? {{WIDE{1'b0}}, r_b} : W2'(0));
    assign w_rem_sh  = r_acc[W2-1:WIDE-1];
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_new = w_ge ? WIDE'(w_rem_sh - {1'b0, r_b}) : WIDE'(w_rem_sh);
    assign w_div_acc = {w_rem_new, r_acc[WIDE-2:0], w_ge};

    // Sign-corrected results for the fix cycle
    logic [W2-1:0]   w_prod;
    logic [WIDE-1:0] w_quo, w_rem;
    assign w_prod = r_sign_q ? ((~r_acc) + W2'(1)) : r_acc;
    assign w_quo  = r_sign_q ? ((~r_acc[WIDE-1:0]) + WIDE'(1)) : r_acc[WIDE-1:0];
    assign w_rem  = r_sign_r ? ((~r_acc[W2-1:WIDE]) + WIDE'(1)) : r_acc[W2-1:WIDE];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_CALC;
            S_CALC:  if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_m_nxt        = r_m;
        w_b_nxt        = r_b;
        w_a_nxt        = r_a;
        w_div_nxt      = r_div;
        w_sign_q_nxt   = r_sign_q;
        w_sign_r_nxt   = r_sign_r;
        w_dz_nxt       = r_dz;
        w_hi_nxt       = r_hi;
        w_lo_nxt       = r_lo;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_div_zero_nxt = r_div_zero;
        case (r_state)
            S_IDLE: begin
                if (i_we_hi) w_hi_nxt = i_wd;
                if (i_we_lo) w_lo_nxt = i_wd;
                if (i_start) begin
                    w_div_nxt    = i_op[1];
                    w_acc_nxt    = i_op[1] ? {{WIDE{1'b0}}, w_a_abs} : W2'(0);
                    w_m_nxt      = w_a_abs;
                    w_b_nxt      = w_b_abs;
                    w_a_nxt      = i_a;
                    w_sign_q_nxt = w_sgn & (i_a[WIDE-1] ^ i_b[WIDE-1]);
                    w_sign_r_nxt = w_sgn & i_a[WIDE-1];
                    w_dz_nxt     = i_op[1] & (i_b == WIDE'(0));
                    w_cnt_nxt    = CW'(WIDE);
                    w_busy_nxt   = 1'b1;
                end
            end
            S_CALC: begin
                w_acc_nxt = r_div ? w_div_acc : w_mul_acc;
                w_m_nxt   = {r_m[WIDE-2:0], 1'b0};
                w_cnt_nxt = r_cnt - CW'(1);
            end
            S_FIX: begin
                if (!r_div) begin
                    w_hi_nxt = w_prod[W2-1:WIDE];
                    w_lo_nxt = w_prod[WIDE-1:0];
                end else if (r_dz) begin
                    w_hi_nxt = r_a;
                    w_lo_nxt = {WIDE{1'b1}};
                end else begin
                    w_hi_nxt = w_rem;
                    w_lo_nxt = w_quo;
                end
                w_busy_nxt     = 1'b0;
                w_done_nxt     = 1'b1;
                w_div_zero_nxt = r_dz;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_m        <= '0;
            r_b        <= '0;
            r_a        <= '0;
            r_div      <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_m        <= w_m_nxt;
            r_b        <= w_b_nxt;
            r_a        <= w_a_nxt;
            r_div      <= w_div_nxt;
            r_sign_q   <= w_sign_q_nxt;
            r_sign_r   <= w_sign_r_nxt;
            r_dz       <= w_dz_nxt;
            r_hi       <= w_hi_nxt;
            r_lo       <= w_lo_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_div_zero_nxt;
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_div_zero = r_div_zero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases, a handshake /
// abort sequence, and random operations compared to an arithmetic model.
module tb_muldiv_seq;

    localparam int unsigned WIDE = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_start;
    logic [1:0]      i_op;
    logic [WIDE-1:0] i_a, i_b, i_wd;
    logic            i_we_hi, i_we_lo;
    logic [WIDE-1:0] o_hi, o_lo;
    logic            o_busy, o_done, o_div_zero;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.WIDE(WIDE)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_a        (i_a),
        .i_b        (i_b),
        .i_we_hi    (i_we_hi),
        .i_we_lo    (i_we_lo),
        .i_wd       (i_wd),
        .o_hi       (o_hi),
        .o_lo       (o_lo),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_div_zero (o_div_zero)
    );

    always #5 clk = ~clk;

    // Count one comparison and report a mismatch
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: returns {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic dz);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (op)
            2'd0: r = {32'd0, a} * {32'd0, b};
            2'd1: r = 64'(sa * sb);
            2'd2: begin
                if (b == 32'd0) begin dz = 1'b1; r = {a, 32'hFFFF_FFFF}; end
                else r = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin dz = 1'b1; r = {a, 32'hFFFF_FFFF}; end
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Issue one operation (caller is #1 after an edge) and check it at done
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit wr);
        logic [63:0] e;
        logic        edz;
        int          nbusy, ndone;
        e = model(op, a, b, edz);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        if (wr) begin i_we_hi = 1'b1; i_we_lo = 1'b1; i_wd = 32'h5A5A_C3C3; end
        @(posedge clk); #1;
        i_start = 1'b0; i_we_hi = 1'b0; i_we_lo = 1'b0;
        i_a = $urandom; i_b = $urandom; i_op = 2'($urandom);
        check("busy_rise", o_busy, 1);
        check("done_fall", o_done, 0);
        if (wr) begin
            check("wr_start_hi", o_hi, 64'h5A5A_C3C3);
            check("wr_start_lo", o_lo, 64'h5A5A_C3C3);
        end
        nbusy = 1; ndone = 0;
        for (int k = 2; k <= int'(WIDE) + 1; k++) begin
            @(posedge clk); #1;
            nbusy += int'(o_busy);
            ndone += int'(o_done);
            i_start = 1'b0; i_we_lo = 1'b0;
            if (disturb && k == 5) begin
                i_start = 1'b1; i_op = 2'd2; i_a = 32'd9; i_b = 32'd3;
                i_we_lo = 1'b1; i_wd = 32'hAA;
            end
        end
        @(posedge clk); #1;
        check("busy_cycles", 64'(nbusy), 64'(WIDE + 1));
        check("early_done", 64'(ndone), 0);
        check("done", o_done, 1);
        check("busy_end", o_busy, 0);
        check("hi", o_hi, {32'd0, e[63:32]});
        check("lo", o_lo, {32'd0, e[31:0]});
        check("div_zero", o_div_zero, edz);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          ndone;
        rst = 1'b1; i_start = 1'b0; i_op = 2'd0; i_a = '0; i_b = '0;
        i_we_hi = 1'b0; i_we_lo = 1'b0; i_wd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_hi", o_hi, 0);
        check("rst_lo", o_lo, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_dz", o_div_zero, 0);

        // Directed cases (chained back-to-back on done cycles)
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 0, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0, 1);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(2'd2, 32'd100, 32'd7, 0, 0);
        run_op(2'd2, 32'd7, 32'd0, 0, 0);
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd3, 32'hFFFF_FFF0, 32'd0, 0, 0);
        run_op(2'd3, 32'd7, 32'hFFFF_FFFE, 0, 0);
        @(posedge clk); #1;
        check("done_pulse", o_done, 0);

        // Direct writes in idle, both ports together
        i_we_hi = 1'b1; i_we_lo = 1'b1; i_wd = 32'hCAFE_0001;
        @(posedge clk); #1;
        i_we_hi = 1'b0; i_we_lo = 1'b0;
        check("idle_wr_hi", o_hi, 64'hCAFE_0001);
        check("idle_wr_lo", o_lo, 64'hCAFE_0001);

        // Start/write during busy ignored, then abort by reset
        run_op(2'd0, 32'd3, 32'd4, 1, 0);
        i_start = 1'b1; i_op = 2'd2; i_a = 32'd100; i_b = 32'd7;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("b2b_busy", o_busy, 1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_hi", o_hi, 0);
        check("abort_lo", o_lo, 0);
        check("abort_busy", o_busy, 0);
        check("abort_done", o_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < int'(WIDE) + 4; k++) begin
            @(posedge clk); #1;
            ndone += int'(o_done);
        end
        check("abort_no_done", 64'(ndone), 0);
        i_we_hi = 1'b1; i_wd = 32'h1234;
        @(posedge clk); #1;
        i_we_hi = 1'b0;
        check("mthi", o_hi, 64'h1234);
        check("mthi_lo", o_lo, 0);

        // Random operations with corner-biased operands
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 255);
                4: rb = -$urandom_range(1, 15);
                default: ;
            endcase
            run_op(rop, ra, rb, 0, (n % 7) == 3);
            if ((n % 5) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath.
- Generalises the combinational unsigned multiplier to four modes: MULTU, MULT, DIVU, DIV.
- Produces one result bit per cycle, using a start/busy/done handshake.
- The controller stalls MFHI/MFLO while busy=1 and drives MTHI/MTLO through the direct write ports.

Parameters:
- WIDE, 32, operand and HI/LO width in bits (≥4, even).
- CW, $clog2(WIDE)+1, iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; captured with start.
- a  in  WIDE  multiplicand / dividend (rs).
- b  in  WIDE  multiplier / divisor (rt).
- we_hi  in  1  direct HI write (MTHI).
- we_lo  in  1  direct LO write (MTLO).
- wd  in  WIDE  direct write data.
- hi  out  WIDE  HI register.
- lo  out  WIDE  LO register.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  last divide had b==0; valid while done=1.

Behaviour:

Reset (asynchronous):
- hi=0, lo=0, busy=0, done=0, div_zero=0.
- FSM goes to IDLE; counter=0.
- Reset mid-operation aborts the operation; no partial result reaches hi/lo.

FSM states IDLE, CALC, FIX.
- IDLE → CALC at an edge where start=1:
  - Latch op.
  - Latch |a| and |b| for signed modes, raw values otherwise.
  - Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (signed modes only).
  - Latch dz = (b==0) for divide modes.
  - counter=WIDE; busy←1.
- CALC runs exactly WIDE cycles, counter decrementing; CALC → FIX when counter reaches 1 on that edge.
  - Multiply: shift-add over a 2·WIDE accumulator, one multiplier bit per cycle.
  - Divide: restoring; shift the remainder/quotient pair left and subtract if no borrow, giving one quotient bit per cycle.
- FIX: one cycle, then → IDLE.
  - Apply sign correction: product negated (2·WIDE bits) if sign_q; quotient negated if sign_q; remainder negated if sign_r.
  - Write {hi,lo}: multiply gives hi=upper product, lo=lower product; divide gives lo=quotient, hi=remainder.
  - On the FIX→IDLE edge: busy←0, done←1 for exactly one cycle, div_zero←dz (0 for multiply).

Latency:
- Result visible and done=1 after the (WIDE+2)th rising edge counted from, and including, the start-sampling edge.
- busy is high for WIDE+1 cycles.
- Back-to-back: start may be asserted in the same cycle done=1 (FSM already IDLE). That request is accepted; done falls and busy rises on the next edge.

Arithmetic rules:
- Divide by zero: iterations still run (fixed latency). Forced result lo = all ones, hi = a (original operand), div_zero=1.
- DIV of most-negative by −1: lo = most-negative, hi = 0. No trap, no flag.
- Signed remainder takes the dividend's sign; quotient truncates toward zero.

Start and write ports:
- start while busy=1 is ignored: no re-capture, no effect on the running operation.
- we_hi/we_lo in IDLE: register ← wd at the edge. Both may be asserted together.
- we_hi/we_lo while busy=1: ignored.
- we_* in the same cycle as an accepted start: the write lands, and is later overwritten by the result.

Other outputs:
- op/a/b may change freely after the start edge.
- done and div_zero are registered, never combinational from inputs.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done pulses at edge 34 after start; busy high 33 cycles.
- MULT a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULT a=0x80000000 b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
- DIVU a=100 b=7 → lo=14, hi=2.
- DIVU a=7 b=0 → lo=0xFFFFFFFF, hi=7, div_zero=1 with done.
- DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshake/abort sequence:
  - Step 1: start MULTU 3×4.
  - Step 2: at cycle 5, pulse start (DIVU 9/3) and we_lo with wd=0xAA → both ignored; result hi=0, lo=12.
  - Step 3: assert start on the done cycle → second op accepted.
  - Step 4: assert rst at cycle 10 of that op → hi=lo=0, busy=0, no done.
  - Step 5: we_hi wd=0x1234 in IDLE → hi=0x1234 next cycle.
